// File: rtl/div_iter_pkg.sv
// Shared state codes and handshake levels for the iterative divider.
package div_iter_pkg;

   typedef enum logic [1:0] {
      DIV_FREE    = 2'b00,
      DIV_BY_ZERO = 2'b01,
      DIV_ON      = 2'b10,
      DIV_END     = 2'b11
   } div_state_e;

   localparam logic DIV_RESULT_READY     = 1'b1;
   localparam logic DIV_RESULT_NOT_READY = 1'b0;
   localparam logic DIV_START            = 1'b1;
   localparam logic DIV_STOP             = 1'b0;

endpackage

// File: rtl/div_iter_step.sv
// One restoring-division iteration: shift {rem, dividend} left, trial subtract, set quotient bit.
module div_iter_step #(
   parameter int WIDTH = 32
) (
   input  logic [2*WIDTH:0] i_acc,
   input  logic [WIDTH-1:0] i_dsr,
   output logic [2*WIDTH:0] o_acc
);

   logic [2*WIDTH:0] w_sh;
   logic [WIDTH+1:0] w_diff;

   assign w_sh   = {i_acc[2*WIDTH-1:0], 1'b0};
   // One extra bit so the borrow shows up as the sign of the difference.
   assign w_diff = i_acc[2*WIDTH:WIDTH-1] - {2'b00, i_dsr};
   assign o_acc  = w_diff[WIDTH+1] ? w_sh
                                   : {w_diff[WIDTH:0], w_sh[WIDTH-1:1], 1'b1};

endmodule

// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider, signed/unsigned, one quotient bit per clock.
module div_iter
   import div_iter_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               signed_i,
   input  logic [WIDTH-1:0]   opdata1_i,
   input  logic [WIDTH-1:0]   opdata2_i,
   input  logic               start_i,
   input  logic               annul_i,
   output logic [2*WIDTH-1:0] result_o,
   output logic               ready_o,
   output logic               busy_o
);

   div_state_e         r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic [2*WIDTH:0]   r_acc;
   logic [WIDTH-1:0]   r_dsr;
   logic               r_qneg;
   logic               r_rneg;
   logic [2*WIDTH-1:0] r_result;
   logic               r_ready;
   logic               r_busy;

   logic               w_a_neg;
   logic               w_b_neg;
   logic [WIDTH-1:0]   w_a_mag;
   logic [WIDTH-1:0]   w_b_mag;
   logic [2*WIDTH:0]   w_acc_nxt;
   logic [WIDTH-1:0]   w_quo;
   logic [WIDTH-1:0]   w_rem;
   logic [WIDTH-1:0]   w_quo_fix;
   logic [WIDTH-1:0]   w_rem_fix;

   assign w_a_neg = signed_i & opdata1_i[WIDTH-1];
   assign w_b_neg = signed_i & opdata2_i[WIDTH-1];
   assign w_a_mag = w_a_neg ? (~opdata1_i + WIDTH'(1)) : opdata1_i;
   assign w_b_mag = w_b_neg ? (~opdata2_i + WIDTH'(1)) : opdata2_i;

   assign w_quo     = r_acc[WIDTH-1:0];
   assign w_rem     = r_acc[2*WIDTH-1:WIDTH];
   assign w_quo_fix = r_qneg ? (~w_quo + WIDTH'(1)) : w_quo;
   assign w_rem_fix = r_rneg ? (~w_rem + WIDTH'(1)) : w_rem;

   div_iter_step #(.WIDTH(WIDTH)) u_step (
      .i_acc (r_acc),
      .i_dsr (r_dsr),
      .o_acc (w_acc_nxt)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= DIV_FREE;
         r_cnt    <= '0;
         r_acc    <= '0;
         r_dsr    <= '0;
         r_qneg   <= 1'b0;
         r_rneg   <= 1'b0;
         r_result <= '0;
         r_ready  <= DIV_RESULT_NOT_READY;
         r_busy   <= 1'b0;
      end else begin
         case (r_state)
            DIV_FREE: begin
               if (start_i == DIV_START && !annul_i) begin
                  r_qneg <= w_a_neg ^ w_b_neg;
                  r_rneg <= w_a_neg;
                  r_dsr  <= w_b_mag;
                  r_cnt  <= '0;
                  r_busy <= 1'b1;
                  // Divide-by-zero keeps the raw dividend so it can be returned as the remainder.
                  if (opdata2_i == '0) begin
                     r_acc   <= {{(WIDTH+1){1'b0}}, opdata1_i};
                     r_state <= DIV_BY_ZERO;
                  end else begin
                     r_acc   <= {{(WIDTH+1){1'b0}}, w_a_mag};
                     r_state <= DIV_ON;
                  end
               end
            end
            DIV_BY_ZERO: begin
               r_busy <= 1'b0;
               if (annul_i) begin
                  r_state <= DIV_FREE;
               end else begin
                  r_result <= {r_acc[WIDTH-1:0], {WIDTH{1'b1}}};
                  r_ready  <= DIV_RESULT_READY;
                  r_state  <= DIV_END;
               end
            end
            DIV_ON: begin
               if (annul_i) begin
                  r_busy  <= 1'b0;
                  r_state <= DIV_FREE;
               end else if (r_cnt == CNT_W'(WIDTH)) begin
                  r_result <= {w_rem_fix, w_quo_fix};
                  r_ready  <= DIV_RESULT_READY;
                  r_busy   <= 1'b0;
                  r_state  <= DIV_END;
               end else begin
                  r_acc <= w_acc_nxt;
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            DIV_END: begin
               if (start_i == DIV_STOP || annul_i) begin
                  r_ready <= DIV_RESULT_NOT_READY;
                  r_state <= DIV_FREE;
               end
            end
            default: r_state <= DIV_FREE;
         endcase
      end
   end

   assign result_o = r_result;
   assign ready_o  = r_ready;
   assign busy_o   = r_busy;

endmodule
